// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode / write-back stage.
//
// Decodes the D pipeline register into source and destination register IDs.
// Reads the 15-entry register file and resolves valA/valB by forwarding from
// the execute, memory and write-back stages. Latches the result into the E
// pipeline register. The register file lives here, and the W stage writes it
// back on every rising edge.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   D_icode/ifun/rA/rB/valC/valP  D pipeline register contents
//   e_dstE/e_valE                 execute result (after cmov condition)
//   M_dstE/M_valE, M_dstM/m_valM  memory-stage E value and load data
//   W_dstE/W_valE, W_dstM/W_valM  write-back ports (also forwarding sources)
//   E_bubble, E_stall             E register control (bubble beats stall)
//   d_srcA/d_srcB                 decoded source IDs for the hazard unit
//   E_*                           E pipeline register outputs
module decode_stage #(
    parameter logic [3:0] RNONE  = 4'hF,
    parameter logic [3:0] RRSP   = 4'h4,
    parameter int         DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [3:0]        D_rA,
    input  logic [3:0]        D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic [3:0]        e_dstE,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        M_dstE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstM,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        W_dstE,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [3:0]        W_dstM,
    input  logic [DATA_W-1:0] W_valM,
    input  logic              E_bubble,
    input  logic              E_stall,
    output logic [3:0]        d_srcA,
    output logic [3:0]        d_srcB,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [3:0]        E_dstE,
    output logic [3:0]        E_dstM,
    output logic [3:0]        E_srcA,
    output logic [3:0]        E_srcB
);

    localparam logic [3:0] iNop    = 4'h1;
    localparam logic [3:0] iRrmovq = 4'h2;
    localparam logic [3:0] iIrmovq = 4'h3;
    localparam logic [3:0] iRmmovq = 4'h4;
    localparam logic [3:0] iMrmovq = 4'h5;
    localparam logic [3:0] iOpq    = 4'h6;
    localparam logic [3:0] iJxx    = 4'h7;
    localparam logic [3:0] iCall   = 4'h8;
    localparam logic [3:0] iRet    = 4'h9;
    localparam logic [3:0] iPushq  = 4'hA;
    localparam logic [3:0] iPopq   = 4'hB;

    logic [DATA_W-1:0] regFile [0:14];

    logic [3:0]        dDstE;
    logic [3:0]        dDstM;
    logic [DATA_W-1:0] rfValA;
    logic [DATA_W-1:0] rfValB;
    logic [DATA_W-1:0] dValA;
    logic [DATA_W-1:0] dValB;

    // Forwarding priority: youngest producer first. Within a stage the M port
    // beats the E port, which matches the write-back order for popq %rsp.
    function automatic logic [DATA_W-1:0] fwdSel(
        input logic [3:0]        src,
        input logic [DATA_W-1:0] rfVal,
        input logic [3:0]        eDst,  input logic [DATA_W-1:0] eVal,
        input logic [3:0]        mDstM, input logic [DATA_W-1:0] mValM,
        input logic [3:0]        mDstE, input logic [DATA_W-1:0] mValE,
        input logic [3:0]        wDstM, input logic [DATA_W-1:0] wValM,
        input logic [3:0]        wDstE, input logic [DATA_W-1:0] wValE
    );
        if (src == RNONE)       return rfVal;
        else if (src == eDst)   return eVal;
        else if (src == mDstM)  return mValM;
        else if (src == mDstE)  return mValE;
        else if (src == wDstM)  return wValM;
        else if (src == wDstE)  return wValE;
        else                    return rfVal;
    endfunction

    // ---- Decode: register IDs from icode ----
    always_comb begin
        d_srcA = RNONE;
        d_srcB = RNONE;
        dDstE  = RNONE;
        dDstM  = RNONE;
        case (D_icode)
            iRrmovq, iRmmovq, iOpq, iPushq: d_srcA = D_rA;
            iRet, iPopq:                    d_srcA = RRSP;
            default:                        d_srcA = RNONE;
        endcase
        case (D_icode)
            iRmmovq, iMrmovq, iOpq:         d_srcB = D_rB;
            iCall, iRet, iPushq, iPopq:     d_srcB = RRSP;
            default:                        d_srcB = RNONE;
        endcase
        case (D_icode)
            iRrmovq, iIrmovq, iOpq:         dDstE = D_rB;
            iCall, iRet, iPushq, iPopq:     dDstE = RRSP;
            default:                        dDstE = RNONE;
        endcase
        case (D_icode)
            iMrmovq, iPopq:                 dDstM = D_rA;
            default:                        dDstM = RNONE;
        endcase
    end

    // Combinational read; ID F is not a register and reads as zero.
    always_comb begin
        rfValA = '0;
        rfValB = '0;
        if (d_srcA != RNONE) rfValA = regFile[d_srcA];
        if (d_srcB != RNONE) rfValB = regFile[d_srcB];
    end

    always_comb begin
        dValA = '0;
        dValB = '0;
        // jXX and call carry the return/fall-through PC in valA.
        if (D_icode == iJxx || D_icode == iCall)
            dValA = D_valP;
        else
            dValA = fwdSel(d_srcA, rfValA, e_dstE, e_valE, M_dstM, m_valM,
                           M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
        dValB = fwdSel(d_srcB, rfValB, e_dstE, e_valE, M_dstM, m_valM,
                       M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    end

    // ---- Write-back: register file update from W ----
    // The M write comes after the E write, so it wins when both target the
    // same register (popq %rsp).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regFile[i] <= '0;
        end else begin
            if (W_dstE != RNONE) regFile[W_dstE] <= W_valE;
            if (W_dstM != RNONE) regFile[W_dstM] <= W_valM;
        end
    end

    // ---- E pipeline register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_icode <= iNop;
            E_ifun  <= '0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else if (E_bubble) begin
            E_icode <= iNop;
            E_ifun  <= '0;
            E_valC  <= '0;
            E_valA  <= '0;
            E_valB  <= '0;
            E_dstE  <= RNONE;
            E_dstM  <= RNONE;
            E_srcA  <= RNONE;
            E_srcB  <= RNONE;
        end else if (!E_stall) begin
            E_icode <= D_icode;
            E_ifun  <= D_ifun;
            E_valC  <= D_valC;
            E_valA  <= dValA;
            E_valB  <= dValB;
            E_dstE  <= dDstE;
            E_dstM  <= dDstM;
            E_srcA  <= d_srcA;
            E_srcB  <= d_srcB;
        end
    end

endmodule
